// File: rtl/mood_pkg.sv
// Shared mood encodings, RGB565 colour constants and default frame geometry
// for mood_frame_gen and its sub-blocks.
package mood_pkg;

  localparam int unsigned DEF_H_RES = 320;
  localparam int unsigned DEF_V_RES = 240;

  typedef enum logic [2:0] {
    MOOD_IDLE      = 3'd0,
    MOOD_TRISTE    = 3'd1,
    MOOD_CARINO    = 3'd2,
    MOOD_DEPRIMIDO = 3'd3,
    MOOD_MUERTO    = 3'd4
  } mood_t;

  localparam logic [15:0] COL_IDLE      = 16'hFFE0;
  localparam logic [15:0] COL_TRISTE    = 16'h07FF;
  localparam logic [15:0] COL_CARINO    = 16'hF800;
  localparam logic [15:0] COL_DEPRIMIDO = 16'h780F;
  localparam logic [15:0] COL_MUERTO    = 16'h0000;
  localparam logic [15:0] COL_INVALID   = 16'h001F;
  localparam logic [15:0] COL_BORDER    = 16'hFFFF;

  // Out-of-range value so any valid mood differs from it after reset
  localparam logic [2:0] MOOD_Q_RST = 3'd7;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  function automatic logic [15:0] mood_colour(input logic [2:0] m);
    case (m)
      MOOD_IDLE:      return COL_IDLE;
      MOOD_TRISTE:    return COL_TRISTE;
      MOOD_CARINO:    return COL_CARINO;
      MOOD_DEPRIMIDO: return COL_DEPRIMIDO;
      MOOD_MUERTO:    return COL_MUERTO;
      default:        return COL_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/mood_frame_gen_if.sv
// Valid/ready pixel stream between the frame generator (master) and the
// display controller (slave).
interface mood_frame_gen_if #(
  parameter int unsigned PIXEL_SIZE = 16
);
  logic                  px_valid;
  logic                  px_ready;
  logic [PIXEL_SIZE-1:0] px_data;
  logic                  px_first;
  logic                  px_last;

  modport master (
    output px_valid,
    output px_data,
    output px_first,
    output px_last,
    input  px_ready
  );

  modport slave (
    input  px_valid,
    input  px_data,
    input  px_first,
    input  px_last,
    output px_ready
  );
endinterface

// File: rtl/xy_counter.sv
// Raster x/y position counter with first/last pixel flags.
// With MOOD_BORDER_EN defined, o_edge flags the 4-pixel frame border.
module xy_counter
  import mood_pkg::*;
#(
  parameter int unsigned H_RES = DEF_H_RES,
  parameter int unsigned V_RES = DEF_V_RES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_advance,
  input  logic i_clear,
  output logic o_first,
  output logic o_last,
  output logic o_edge
);

  localparam int unsigned XW = $clog2(H_RES);
  localparam int unsigned YW = $clog2(V_RES);
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (r_x == X_MAX) begin
        r_x <= '0;
        r_y <= (r_y == Y_MAX) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_first = (r_x == '0) && (r_y == '0);
  assign o_last  = (r_x == X_MAX) && (r_y == Y_MAX);

`ifdef MOOD_BORDER_EN
  localparam logic [XW-1:0] X_LO = XW'(4);
  localparam logic [YW-1:0] Y_LO = YW'(4);
  localparam logic [XW-1:0] X_HI = XW'(H_RES - 4);
  localparam logic [YW-1:0] Y_HI = YW'(V_RES - 4);

  assign o_edge = (r_x < X_LO) || (r_x >= X_HI) || (r_y < Y_LO) || (r_y >= Y_HI);
`else
  assign o_edge = 1'b0;
`endif

endmodule

// File: rtl/mood_frame_gen.sv
// Streams one full RGB565 frame coloured by the latched mood, on request or on
// mood change. MOOD_BORDER_EN adds a white 4-pixel border.
module mood_frame_gen
  import mood_pkg::*;
#(
  parameter int unsigned H_RES      = DEF_H_RES,
  parameter int unsigned V_RES      = DEF_V_RES,
  parameter int unsigned PIXEL_SIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mood,
  input  logic             frame_req,
  mood_frame_gen_if.master px,
  output logic             busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_mood_q;
  logic        r_pending;
  logic        w_start;
  logic        w_valid;
  logic        w_xfer;
  logic        w_first;
  logic        w_last;
  logic        w_edge;
  logic [15:0] w_colour;

  xy_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_xy (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_xfer),
    .i_clear   (w_start),
    .o_first   (w_first),
    .o_last    (w_last),
    .o_edge    (w_edge)
  );

  assign w_valid = (r_state == ST_STREAM);
  assign w_xfer  = w_valid && px.px_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Request, pending request and mood change all collapse into one start
        if (frame_req || r_pending || (mood != r_mood_q)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_xfer && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mood_q  <= MOOD_Q_RST;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) r_mood_q <= mood;
      if (w_start) begin
        r_pending <= 1'b0;
      end else if (w_valid && frame_req) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Outputs derive only from registered state, so they hold while stalled
  assign w_colour    = w_edge ? COL_BORDER : mood_colour(r_mood_q);
  assign px.px_valid = w_valid;
  assign px.px_data  = w_valid ? PIXEL_SIZE'(w_colour) : '0;
  assign px.px_first = w_valid && w_first;
  assign px.px_last  = w_valid && w_last;
  assign busy        = w_valid;

endmodule

// File: tb/tb_mood_frame_gen.sv
// Randomised self-checking bench for mood_frame_gen on a reduced 12x10 frame,
// compared against a per-pixel reference model of the colour rules.
module tb_mood_frame_gen;

  localparam int H = 12;
  localparam int V = 10;
  localparam int N = H * V;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mood;
  logic       frame_req;
  logic       busy;

  int tests = 0;
  int fails = 0;

  mood_frame_gen_if #(.PIXEL_SIZE(16)) px_if ();

  mood_frame_gen #(
    .H_RES      (H),
    .V_RES      (V),
    .PIXEL_SIZE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mood      (mood),
    .frame_req (frame_req),
    .px        (px_if.master),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Results of the most recent collect() call
  logic [15:0] got[$];
  int c_wait, c_valid, c_first_idx, c_last_idx, c_nfirst, c_nlast;
  int c_unstable, c_busybad;
  bit c_timeout;

  function automatic logic [15:0] ref_pixel(input logic [2:0] m, input int idx);
    int x = idx % H;
    int y = idx / H;
    logic [15:0] c;
    case (m)
      3'd0: c = 16'hFFE0;
      3'd1: c = 16'h07FF;
      3'd2: c = 16'hF800;
      3'd3: c = 16'h780F;
      3'd4: c = 16'h0000;
      default: c = 16'h001F;
    endcase
`ifdef MOOD_BORDER_EN
    if (x < 4 || x >= H - 4 || y < 4 || y >= V - 4) c = 16'hFFFF;
`endif
    return c;
  endfunction

  function automatic int count_bad(input logic [2:0] m);
    int b = 0;
    foreach (got[i]) if (got[i] !== ref_pixel(m, i)) b++;
    return b;
  endfunction

  // ready_mode: 0 always ready, 1 alternate starting stalled, 2 random
  task automatic collect(input int ready_mode, input int change_at, input logic [2:0] change_mood,
                         input int n_req, input int abort_at, input bit pulse_req);
    bit ready;
    bit prev_stall;
    logic [15:0] pd;
    logic pf, pl;
    got.delete();
    c_wait = 0; c_valid = 0; c_first_idx = -1; c_last_idx = -1;
    c_nfirst = 0; c_nlast = 0; c_unstable = 0; c_busybad = 0; c_timeout = 0;
    prev_stall = 0; pd = '0; pf = 0; pl = 0;
    if (pulse_req) frame_req = 1'b1;
    forever begin
      @(negedge clk);
      frame_req = 1'b0;
      if (busy !== px_if.px_valid) c_busybad++;
      if (px_if.px_valid === 1'b1) break;
      c_wait++;
      if (c_wait > 50) begin c_timeout = 1; return; end
    end
    forever begin
      if (px_if.px_valid !== 1'b1) begin c_timeout = 1; return; end
      if (prev_stall && (px_if.px_data !== pd || px_if.px_first !== pf || px_if.px_last !== pl))
        c_unstable++;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = (c_valid % 2 == 1);
        default: ready = ($urandom_range(0, 1) == 1);
      endcase
      px_if.px_ready = ready;
      c_valid++;
      if (ready) begin
        if (px_if.px_first === 1'b1) begin c_nfirst++; c_first_idx = got.size(); end
        if (px_if.px_last === 1'b1) begin c_nlast++; c_last_idx = got.size(); end
        got.push_back(px_if.px_data);
        if (got.size() == change_at) mood = change_mood;
        if (n_req > 0 && got.size() % 10 == 0 && got.size() / 10 <= n_req) frame_req = 1'b1;
        if (px_if.px_last === 1'b1) return;
        if (abort_at > 0 && got.size() == abort_at) return;
      end
      prev_stall = !ready;
      pd = px_if.px_data; pf = px_if.px_first; pl = px_if.px_last;
      if (c_valid > 10 * N) begin c_timeout = 1; return; end
      @(negedge clk);
      frame_req = 1'b0;
      if (busy !== px_if.px_valid) c_busybad++;
    end
  endtask

  task automatic watch_idle(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (px_if.px_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mood = 3'd1; frame_req = 1'b0; px_if.px_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (px_if.px_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", px_if.px_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (px_if.px_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", px_if.px_data); end
    tests++; if (px_if.px_first !== 1'b0 || px_if.px_last !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got first=%b last=%b expected 0 0", px_if.px_first, px_if.px_last); end
  endtask

  task automatic test_basic();
    int seen;
    rst = 1'b0;
    collect(0, -1, 3'd0, 0, 0, 1'b0);
    tests++; if (c_timeout !== 1'b0) begin fails++; $display("FAIL basic_timeout: got %b expected 0", c_timeout); end
    tests++; if (c_wait !== 0) begin fails++; $display("FAIL basic_latency: got %0d expected 0", c_wait); end
    tests++; if (got.size() !== N) begin fails++; $display("FAIL basic_count: got %0d expected %0d", got.size(), N); end
    tests++; if (count_bad(3'd1) !== 0) begin fails++; $display("FAIL basic_pixels: got %0d bad expected 0", count_bad(3'd1)); end
    tests++; if (c_first_idx !== 0 || c_nfirst !== 1) begin
      fails++; $display("FAIL basic_first: got idx %0d n %0d expected 0 1", c_first_idx, c_nfirst); end
    tests++; if (c_last_idx !== N - 1 || c_nlast !== 1) begin
      fails++; $display("FAIL basic_last: got idx %0d n %0d expected %0d 1", c_last_idx, c_nlast, N - 1); end
    tests++; if (c_busybad !== 0) begin fails++; $display("FAIL basic_busy: got %0d mismatches expected 0", c_busybad); end
    @(negedge clk);
    tests++; if (px_if.px_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_end: got valid=%b busy=%b expected 0 0", px_if.px_valid, busy); end
    watch_idle(10, seen);
    tests++; if (seen !== 0) begin fails++; $display("FAIL basic_stays_idle: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_stall();
    collect(1, -1, 3'd0, 0, 0, 1'b1);
    tests++; if (c_wait !== 0 || c_timeout !== 1'b0) begin
      fails++; $display("FAIL stall_start: got wait %0d timeout %b expected 0 0", c_wait, c_timeout); end
    tests++; if (got.size() !== N) begin fails++; $display("FAIL stall_count: got %0d expected %0d", got.size(), N); end
    tests++; if (c_valid !== 2 * N) begin fails++; $display("FAIL stall_cycles: got %0d expected %0d", c_valid, 2 * N); end
    tests++; if (c_unstable !== 0) begin fails++; $display("FAIL stall_hold: got %0d changes expected 0", c_unstable); end
    tests++; if (count_bad(3'd1) !== 0) begin fails++; $display("FAIL stall_pixels: got %0d bad expected 0", count_bad(3'd1)); end
    tests++; if (c_first_idx !== 0 || c_last_idx !== N - 1) begin
      fails++; $display("FAIL stall_marks: got first %0d last %0d expected 0 %0d", c_first_idx, c_last_idx, N - 1); end
    @(negedge clk);
  endtask

  task automatic test_mood_change();
    mood = 3'd2;
    collect(2, N / 2, 3'd3, 0, 0, 1'b0);
    tests++; if (got.size() !== N) begin fails++; $display("FAIL mood_count: got %0d expected %0d", got.size(), N); end
    tests++; if (count_bad(3'd2) !== 0) begin fails++; $display("FAIL mood_latched: got %0d bad expected 0", count_bad(3'd2)); end
    collect(0, -1, 3'd0, 0, 0, 1'b0);
    tests++; if (c_wait !== 1) begin fails++; $display("FAIL mood_refresh_gap: got %0d expected 1", c_wait); end
    tests++; if (got.size() !== N || count_bad(3'd3) !== 0) begin
      fails++; $display("FAIL mood_refresh: got size %0d bad %0d expected %0d 0", got.size(), count_bad(3'd3), N); end
    @(negedge clk);
  endtask

  task automatic test_pending();
    int seen;
    mood = 3'd6;
    collect(2, -1, 3'd0, 3, 0, 1'b0);
    tests++; if (got.size() !== N || count_bad(3'd6) !== 0) begin
      fails++; $display("FAIL pend_frame1: got size %0d bad %0d expected %0d 0", got.size(), count_bad(3'd6), N); end
    collect(2, -1, 3'd0, 0, 0, 1'b0);
    tests++; if (c_wait !== 1 || c_timeout !== 1'b0) begin
      fails++; $display("FAIL pend_restart: got wait %0d timeout %b expected 1 0", c_wait, c_timeout); end
    tests++; if (got.size() !== N || count_bad(3'd6) !== 0) begin
      fails++; $display("FAIL pend_frame2: got size %0d bad %0d expected %0d 0", got.size(), count_bad(3'd6), N); end
    watch_idle(20, seen);
    tests++; if (seen !== 0) begin fails++; $display("FAIL pend_merge: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_req_and_mood();
    int seen;
    mood = 3'd4;
    collect(0, -1, 3'd0, 0, 0, 1'b1);
    tests++; if (got.size() !== N || count_bad(3'd4) !== 0) begin
      fails++; $display("FAIL both_frame: got size %0d bad %0d expected %0d 0", got.size(), count_bad(3'd4), N); end
    watch_idle(20, seen);
    tests++; if (seen !== 0) begin fails++; $display("FAIL both_single: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    mood = 3'd0;
    collect(0, -1, 3'd0, 0, N / 2, 1'b0);
    rst = 1'b1;
    #1;
    tests++; if (px_if.px_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL abort_valid: got valid=%b busy=%b expected 0 0", px_if.px_valid, busy); end
    @(negedge clk);
    rst = 1'b0;
    collect(2, -1, 3'd0, 0, 0, 1'b0);
    tests++; if (c_wait !== 0 || c_first_idx !== 0) begin
      fails++; $display("FAIL abort_restart: got wait %0d first %0d expected 0 0", c_wait, c_first_idx); end
    tests++; if (got.size() !== N || count_bad(3'd0) !== 0) begin
      fails++; $display("FAIL abort_frame: got size %0d bad %0d expected %0d 0", got.size(), count_bad(3'd0), N); end
`ifdef MOOD_BORDER_EN
    tests++; if (got[0] !== 16'hFFFF || got[N - 1] !== 16'hFFFF) begin
      fails++; $display("FAIL border_corners: got %h %h expected FFFF FFFF", got[0], got[N - 1]); end
    tests++; if (got[4 * H + 4] !== 16'hFFE0) begin
      fails++; $display("FAIL border_inner: got %h expected FFE0", got[4 * H + 4]); end
`else
    tests++; if (got[0] !== 16'hFFE0 || got[N - 1] !== 16'hFFE0) begin
      fails++; $display("FAIL plain_corners: got %h %h expected FFE0 FFE0", got[0], got[N - 1]); end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] m;
    for (int i = 0; i < 4; i++) begin
      m = 3'($urandom_range(0, 7));
      mood = m;
      collect(2, -1, 3'd0, 0, 0, 1'b1);
      tests++; if (c_timeout !== 1'b0 || got.size() !== N || count_bad(m) !== 0) begin
        fails++; $display("FAIL random_frame%0d: mood %0d got size %0d bad %0d timeout %b expected %0d 0 0",
                          i, m, got.size(), count_bad(m), c_timeout, N); end
      tests++; if (c_nfirst !== 1 || c_nlast !== 1 || c_unstable !== 0) begin
        fails++; $display("FAIL random_marks%0d: got first %0d last %0d unstable %0d expected 1 1 0",
                          i, c_nfirst, c_nlast, c_unstable); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mood_change();
    test_pending();
    test_req_and_mood();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mood_frame_gen.md
MOOD_FRAME_GEN -- requirements
Module: mood_frame_gen

Interface
REQ-001 Parameter H_RES, default 320, pixels per line.
REQ-002 Parameter V_RES, default 240, lines per frame.
REQ-003 Parameter PIXEL_SIZE, default 16, RGB565 pixel width.
REQ-004 clk  input  1  sole clock, all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 mood  input  3  requested display state: 0 IDLE, 1 TRISTE, 2 CARINO, 3 DEPRIMIDO, 4 MUERTO.
REQ-007 frame_req  input  1  one-cycle request to stream a full frame.
REQ-008 px_ready  input  1  downstream display controller accepts the pixel.
REQ-009 px_valid  output  1  px_data holds a valid pixel.
REQ-010 px_data  output  PIXEL_SIZE  RGB565 pixel.
REQ-011 px_first  output  1  marks pixel (0,0) of a frame.
REQ-012 px_last  output  1  marks pixel (H_RES-1,V_RES-1).
REQ-013 busy  output  1  a frame is in progress.

Function
REQ-014 FSM states SHALL be IDLE and STREAM.
REQ-015 IDLE -> STREAM SHALL occur on frame_req=1, or on mood != mood_q (auto-refresh).
REQ-016 On entry to STREAM, mood SHALL be latched into mood_q; mood changes mid-frame SHALL NOT affect the current frame.
REQ-017 px_valid SHALL rise on the cycle after the IDLE->STREAM edge and stay high until the px_last transfer.
REQ-018 A transfer SHALL occur on a cycle with px_valid=1 and px_ready=1; x SHALL then increment, wrapping to 0 at H_RES-1 with y incrementing.
REQ-019 While px_valid=1 and px_ready=0, px_data, px_first and px_last SHALL hold stable.
REQ-020 Pixel colour SHALL be set from mood_q: 0 0xFFE0, 1 0x07FF, 2 0xF800, 3 0x780F, 4 0x0000, 5-7 0x001F.
REQ-021 Transfer of px_last SHALL return the FSM to IDLE; px_valid and busy SHALL be 0 the next cycle.
REQ-022 frame_req during STREAM SHALL be remembered (one pending flag) and start a new frame right after the current one ends; further requests SHALL merge into it.
REQ-023 If frame_req and a mood change occur in the same IDLE cycle, exactly one frame SHALL start.
REQ-024 x, y SHALL be $clog2(H_RES), $clog2(V_RES) bits wide; total pixels per frame SHALL be exactly H_RES*V_RES.
REQ-025 busy SHALL be 1 exactly while state is STREAM.

Reset
REQ-026 rst SHALL force IDLE, x=y=0, px_valid=0, px_first=0, px_last=0, px_data=0, busy=0, pending=0.
REQ-027 After reset, mood_q SHALL be 3'd7, so the first cycle after reset triggers a frame for any valid mood.
REQ-028 rst asserted mid-frame SHALL abort the frame immediately; no partial-frame resume.

Configuration
REQ-029 Macro MOOD_BORDER_EN: when defined, pixels with x<4, x>=H_RES-4, y<4 or y>=V_RES-4 SHALL be 0xFFFF; all other pixels SHALL use the mood colour.
REQ-030 Without MOOD_BORDER_EN, every pixel of a frame SHALL be the mood colour.

Structure
REQ-031 Shared package mood_pkg SHALL hold mood encodings, the five RGB565 colour constants, the invalid-mood colour 0x001F and default H_RES/V_RES.
REQ-032 Sub-module xy_counter SHALL hold the x/y counters with advance, clear, first and last outputs.

Verification
REQ-033 Reset, then mood=1 with px_ready=1 -> frame starts, 76800 transfers, all 0x07FF, px_first on transfer 0, px_last on transfer 76799.
REQ-034 px_ready toggling 1/0 every cycle -> px_data stable while stalled; frame takes 153600 valid cycles; no duplicated or dropped pixels.
REQ-035 mood 2->3 at pixel 1000 -> rest of frame stays 0xF800; next frame 0x780F starts the cycle after px_last plus one.
REQ-036 mood=6 -> all pixels 0x001F; three frame_req pulses mid-frame -> exactly one extra frame.
REQ-037 rst pulse at pixel 5000 -> px_valid=0 the same cycle; next frame restarts at px_first.
REQ-038 MOOD_BORDER_EN defined, mood=0 -> (0,0) and (319,239) = 0xFFFF; (4,4) = 0xFFE0.
